vie_mem_arb: RTL and testbench

VIE_MEM_ARB -- requirements
Module: vie_mem_arb

---
 rtl/vie_mem_arb_pkg.sv | 15 +
 rtl/vie_mem_arb_rr_arb2.sv | 22 ++
 rtl/vie_mem_arb.sv | 131 +++++++++++++
 tb/tb_vie_mem_arb.sv | 537 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vie_mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding, owner constants and the fixed size of a fetch.
package vie_mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   localparam logic       OWN_INST  = 1'b0;
   localparam logic       OWN_DATA  = 1'b1;
   localparam logic [1:0] INST_SIZE = 2'b11;

endpackage

// File: rtl/vie_mem_arb_rr_arb2.sv
// Two-requester arbiter: bit 0 = inst, bit 1 = data. Either fixed data
// priority or alternation against the last granted requester.
module vie_rr_arb2
   import vie_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       data_prio,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (data_prio || last_gnt == OWN_INST) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/vie_mem_arb.sv
// Arbitrates a fetch port and a load/store port onto one memory bus with at
// most one outstanding transaction; a flush drops the pending fetch response.
module vie_mem_arb
   import vie_mem_arb_pkg::*;
#(
   parameter logic DATA_PRIO = 1'b0
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   input  logic        flush,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   arb_state_t  state_reg;
   logic        owner_reg;
   logic        last_reg;
   logic        drop_reg;
   logic        wr_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;

   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        drop_now;
   logic        addr_phase;
   logic        data_phase;

   // A flushed fetch is never granted, so it cannot start a transaction.
   assign req = {data_req, inst_req & ~flush};

   vie_rr_arb2 u_arb (
      .req       (req),
      .data_prio (DATA_PRIO),
      .last_gnt  (last_reg),
      .gnt       (gnt)
   );

   // The flush cycle itself already suppresses the fetch handshake pulses.
   assign drop_now = drop_reg | (flush & (owner_reg == OWN_INST));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         owner_reg <= OWN_INST;
         last_reg  <= OWN_INST;
         drop_reg  <= 1'b0;
         wr_reg    <= 1'b0;
         size_reg  <= 2'b00;
         addr_reg  <= 32'h0;
         wdata_reg <= 32'h0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|gnt) begin
                  owner_reg <= gnt[1];
                  last_reg  <= gnt[1];
                  drop_reg  <= 1'b0;
                  state_reg <= ST_ADDR;
                  if (gnt[1]) begin
                     wr_reg    <= data_wr;
                     size_reg  <= data_size;
                     addr_reg  <= data_addr;
                     wdata_reg <= data_wdata;
                  end else begin
                     wr_reg    <= 1'b0;
                     size_reg  <= INST_SIZE;
                     addr_reg  <= inst_addr;
                     wdata_reg <= 32'h0;
                  end
               end
            end
            ST_ADDR: begin
               drop_reg <= drop_now;
               if (mem_addr_ok) begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_data_ok) begin
                  drop_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  drop_reg <= drop_now;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Outputs are held quiet while reset is asserted, even mid-transaction.
   assign addr_phase = (state_reg == ST_ADDR) & ~reset;
   assign data_phase = (state_reg == ST_WAIT) & ~reset;

   assign mem_req   = addr_phase;
   assign mem_wr    = wr_reg;
   assign mem_size  = size_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;

   assign inst_addr_ok = addr_phase & mem_addr_ok & (owner_reg == OWN_INST) & ~drop_now;
   assign inst_data_ok = data_phase & mem_data_ok & (owner_reg == OWN_INST) & ~drop_now;
   assign data_addr_ok = addr_phase & mem_addr_ok & (owner_reg == OWN_DATA);
   assign data_data_ok = data_phase & mem_data_ok & (owner_reg == OWN_DATA);

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_vie_mem_arb.sv
// Bench for vie_mem_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model; instance 0 is round-robin, 1 data-priority.
module tb_vie_mem_arb;

   logic        clock;
   logic        reset        [2];
   logic        inst_req     [2];
   logic [31:0] inst_addr    [2];
   logic        inst_addr_ok [2];
   logic        inst_data_ok [2];
   logic [31:0] inst_rdata   [2];
   logic        data_req     [2];
   logic        data_wr      [2];
   logic [1:0]  data_size    [2];
   logic [31:0] data_addr    [2];
   logic [31:0] data_wdata   [2];
   logic        data_addr_ok [2];
   logic        data_data_ok [2];
   logic [31:0] data_rdata   [2];
   logic        flush        [2];
   logic        mem_req      [2];
   logic        mem_wr       [2];
   logic [1:0]  mem_size     [2];
   logic [31:0] mem_addr     [2];
   logic [31:0] mem_wdata    [2];
   logic        mem_addr_ok  [2];
   logic        mem_data_ok  [2];
   logic [31:0] mem_rdata    [2];

   int n_cmp = 0;
   int n_bad = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      vie_mem_arb #(.DATA_PRIO(1'(gi))) u_dut (
         .clock        (clock),
         .reset        (reset[gi]),
         .inst_req     (inst_req[gi]),
         .inst_addr    (inst_addr[gi]),
         .inst_addr_ok (inst_addr_ok[gi]),
         .inst_data_ok (inst_data_ok[gi]),
         .inst_rdata   (inst_rdata[gi]),
         .data_req     (data_req[gi]),
         .data_wr      (data_wr[gi]),
         .data_size    (data_size[gi]),
         .data_addr    (data_addr[gi]),
         .data_wdata   (data_wdata[gi]),
         .data_addr_ok (data_addr_ok[gi]),
         .data_data_ok (data_data_ok[gi]),
         .data_rdata   (data_rdata[gi]),
         .flush        (flush[gi]),
         .mem_req      (mem_req[gi]),
         .mem_wr       (mem_wr[gi]),
         .mem_size     (mem_size[gi]),
         .mem_addr     (mem_addr[gi]),
         .mem_wdata    (mem_wdata[gi]),
         .mem_addr_ok  (mem_addr_ok[gi]),
         .mem_data_ok  (mem_data_ok[gi]),
         .mem_rdata    (mem_rdata[gi])
      );
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic clear_inputs(input int d);
      inst_req[d]    = 1'b0;
      inst_addr[d]   = 32'h0;
      data_req[d]    = 1'b0;
      data_wr[d]     = 1'b0;
      data_size[d]   = 2'b00;
      data_addr[d]   = 32'h0;
      data_wdata[d]  = 32'h0;
      flush[d]       = 1'b0;
      mem_addr_ok[d] = 1'b0;
      mem_data_ok[d] = 1'b0;
      mem_rdata[d]   = 32'h0;
   endtask

   task automatic apply_reset(input int d);
      tick();
      clear_inputs(d);
      reset[d] = 1'b1;
      tick();
      reset[d] = 1'b0;
   endtask

   // Outputs stay 0 under reset even while requests and handshakes are active.
   task automatic test_reset(input int d);
      tick();
      reset[d]       = 1'b1;
      inst_req[d]    = 1'b1;
      data_req[d]    = 1'b1;
      mem_addr_ok[d] = 1'b1;
      mem_data_ok[d] = 1'b1;
      tick();
      mid();
      n_cmp++;
      if (mem_req[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mem_req[%0d]: got %b expected 0", d, mem_req[d]);
      end
      n_cmp++;
      if ({inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_oks[%0d]: got %b expected 0000", d,
                  {inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]});
      end
      n_cmp++;
      if ({mem_addr[d], mem_wdata[d]} !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_regs[%0d]: got addr %h wdata %h expected 0", d, mem_addr[d], mem_wdata[d]);
      end
      tick();
      reset[d] = 1'b0;
      clear_inputs(d);
      $display("reset[%0d] checked", d);
   endtask

   task automatic test_fetch(input int d);
      apply_reset(d);
      tick();
      inst_req[d]  = 1'b1;
      inst_addr[d] = 32'hbfc00000;
      mid();
      n_cmp++;
      if (mem_req[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_req_early: got %b expected 0", mem_req[d]);
      end
      tick();
      mid();
      n_cmp++;
      if ({mem_req[d], mem_wr[d], mem_size[d], mem_addr[d]} !== {1'b1, 1'b0, 2'b11, 32'hbfc00000}) begin
         n_bad++;
         $display("FAIL fetch_issue: got req %b wr %b size %b addr %h expected 1 0 11 bfc00000",
                  mem_req[d], mem_wr[d], mem_size[d], mem_addr[d]);
      end
      tick();
      mem_addr_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if ({inst_addr_ok[d], data_addr_ok[d]} !== 2'b10) begin
         n_bad++;
         $display("FAIL fetch_addr_ok: got %b expected 10", {inst_addr_ok[d], data_addr_ok[d]});
      end
      tick();
      inst_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      mid();
      n_cmp++;
      if (mem_req[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_req_drop: got %b expected 0", mem_req[d]);
      end
      tick();
      mem_data_ok[d] = 1'b1;
      mem_rdata[d]   = 32'h3c1d0001;
      mid();
      n_cmp++;
      if ({inst_data_ok[d], data_data_ok[d], inst_rdata[d]} !== {2'b10, 32'h3c1d0001}) begin
         n_bad++;
         $display("FAIL fetch_data: got ok %b rdata %h expected 10 3c1d0001",
                  {inst_data_ok[d], data_data_ok[d]}, inst_rdata[d]);
      end
      tick();
      clear_inputs(d);
      $display("fetch bfc00000 -> rdata %h", inst_rdata[d]);
   endtask

   task automatic test_data_prio(input int d);
      apply_reset(d);
      tick();
      inst_req[d]   = 1'b1;
      inst_addr[d]  = 32'h00001000;
      data_req[d]   = 1'b1;
      data_wr[d]    = 1'b1;
      data_size[d]  = 2'd3;
      data_addr[d]  = 32'h80000010;
      data_wdata[d] = 32'hdeadbeef;
      tick();
      mem_addr_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if ({mem_req[d], mem_wr[d], mem_size[d], mem_addr[d], mem_wdata[d]} !==
          {1'b1, 1'b1, 2'd3, 32'h80000010, 32'hdeadbeef}) begin
         n_bad++;
         $display("FAIL prio_store_issue: got req %b wr %b size %b addr %h wdata %h expected 1 1 11 80000010 deadbeef",
                  mem_req[d], mem_wr[d], mem_size[d], mem_addr[d], mem_wdata[d]);
      end
      n_cmp++;
      if ({data_addr_ok[d], inst_addr_ok[d]} !== 2'b10) begin
         n_bad++;
         $display("FAIL prio_addr_ok: got data/inst %b expected 10", {data_addr_ok[d], inst_addr_ok[d]});
      end
      tick();
      data_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      tick();
      mem_data_ok[d] = 1'b1;
      mem_rdata[d]   = 32'h00000011;
      mid();
      n_cmp++;
      if ({data_data_ok[d], inst_data_ok[d], data_rdata[d]} !== {2'b10, 32'h00000011}) begin
         n_bad++;
         $display("FAIL prio_store_done: got ok %b rdata %h expected 10 00000011",
                  {data_data_ok[d], inst_data_ok[d]}, data_rdata[d]);
      end
      tick();
      mem_data_ok[d] = 1'b0;
      mid();
      n_cmp++;
      if (mem_req[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL prio_idle_gap: got %b expected 0", mem_req[d]);
      end
      tick();
      mid();
      n_cmp++;
      if ({mem_req[d], mem_wr[d], mem_size[d], mem_addr[d]} !== {1'b1, 1'b0, 2'b11, 32'h00001000}) begin
         n_bad++;
         $display("FAIL prio_fetch_issue: got req %b wr %b size %b addr %h expected 1 0 11 00001000",
                  mem_req[d], mem_wr[d], mem_size[d], mem_addr[d]);
      end
      tick();
      mem_addr_ok[d] = 1'b1;
      tick();
      inst_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      mem_data_ok[d] = 1'b1;
      mem_rdata[d]   = 32'h00000022;
      mid();
      n_cmp++;
      if (inst_data_ok[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL prio_fetch_done: got %b expected 1", inst_data_ok[d]);
      end
      tick();
      clear_inputs(d);
      $display("data priority: store then fetch");
   endtask

   task automatic test_round_robin(input int d);
      logic [31:0] exp_addr;
      logic        exp_data;
      bit          found;
      apply_reset(d);
      tick();
      inst_req[d]  = 1'b1;
      inst_addr[d] = 32'h00000100;
      data_req[d]  = 1'b1;
      data_addr[d] = 32'h00000200;
      data_size[d] = 2'd2;
      for (int k = 0; k < 4; k++) begin
         exp_data = (k % 2 == 0);
         exp_addr = exp_data ? 32'h00000200 : 32'h00000100;
         found = 1'b0;
         for (int c = 0; c < 8; c++) begin
            mid();
            if (mem_req[d] === 1'b1) begin
               found = 1'b1;
               break;
            end
            tick();
         end
         n_cmp++;
         if (!found) begin
            n_bad++;
            $display("FAIL rr_timeout[%0d]: no mem_req within 8 cycles", k);
            return;
         end
         n_cmp++;
         if (mem_addr[d] !== exp_addr) begin
            n_bad++;
            $display("FAIL rr_order[%0d]: got addr %h expected %h", k, mem_addr[d], exp_addr);
         end
         tick();
         mem_addr_ok[d] = 1'b1;
         mid();
         n_cmp++;
         if ({data_addr_ok[d], inst_addr_ok[d]} !== {exp_data, ~exp_data}) begin
            n_bad++;
            $display("FAIL rr_addr_ok[%0d]: got data/inst %b expected %b", k,
                     {data_addr_ok[d], inst_addr_ok[d]}, {exp_data, ~exp_data});
         end
         tick();
         mem_addr_ok[d] = 1'b0;
         mem_data_ok[d] = 1'b1;
         mem_rdata[d]   = 32'(k);
         mid();
         n_cmp++;
         if ({data_data_ok[d], inst_data_ok[d]} !== {exp_data, ~exp_data}) begin
            n_bad++;
            $display("FAIL rr_data_ok[%0d]: got data/inst %b expected %b", k,
                     {data_data_ok[d], inst_data_ok[d]}, {exp_data, ~exp_data});
         end
         $display("round robin grant %0d -> %s", k, exp_data ? "data" : "inst");
         tick();
         mem_data_ok[d] = 1'b0;
      end
      clear_inputs(d);
   endtask

   task automatic test_flush(input int d);
      apply_reset(d);
      tick();
      inst_req[d]  = 1'b1;
      inst_addr[d] = 32'hbfc00100;
      tick();
      flush[d] = 1'b1;
      mid();
      n_cmp++;
      if (mem_req[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_req_held: got %b expected 1", mem_req[d]);
      end
      tick();
      flush[d]       = 1'b0;
      mem_addr_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if (inst_addr_ok[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_addr_ok: got %b expected 0", inst_addr_ok[d]);
      end
      tick();
      inst_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      tick();
      mem_data_ok[d] = 1'b1;
      mem_rdata[d]   = 32'h12345678;
      mid();
      n_cmp++;
      if (inst_data_ok[d] !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_data_ok: got %b expected 0", inst_data_ok[d]);
      end
      tick();
      mem_data_ok[d] = 1'b0;
      tick();
      inst_req[d]  = 1'b1;
      inst_addr[d] = 32'hbfc00200;
      tick();
      mid();
      n_cmp++;
      if ({mem_req[d], mem_addr[d]} !== {1'b1, 32'hbfc00200}) begin
         n_bad++;
         $display("FAIL flush_refetch_issue: got req %b addr %h expected 1 bfc00200", mem_req[d], mem_addr[d]);
      end
      tick();
      mem_addr_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if (inst_addr_ok[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_refetch_addr_ok: got %b expected 1", inst_addr_ok[d]);
      end
      tick();
      inst_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      mem_data_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if (inst_data_ok[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_refetch_data_ok: got %b expected 1", inst_data_ok[d]);
      end
      tick();
      clear_inputs(d);
      $display("flush drops one fetch, refetch served");
   endtask

   task automatic test_reset_in_wait(input int d);
      apply_reset(d);
      tick();
      inst_req[d]  = 1'b1;
      inst_addr[d] = 32'hbfc00300;
      tick();
      tick();
      mem_addr_ok[d] = 1'b1;
      tick();
      inst_req[d]    = 1'b0;
      mem_addr_ok[d] = 1'b0;
      tick();
      reset[d]       = 1'b1;
      mem_data_ok[d] = 1'b1;
      mid();
      n_cmp++;
      if ({mem_req[d], inst_data_ok[d]} !== 2'b00) begin
         n_bad++;
         $display("FAIL wait_reset_outputs: got req/ok %b expected 00", {mem_req[d], inst_data_ok[d]});
      end
      tick();
      reset[d] = 1'b0;
      mid();
      n_cmp++;
      if ({mem_req[d], inst_data_ok[d], data_data_ok[d]} !== 3'b000) begin
         n_bad++;
         $display("FAIL wait_reset_late_data: got req/iok/dok %b expected 000",
                  {mem_req[d], inst_data_ok[d], data_data_ok[d]});
      end
      tick();
      clear_inputs(d);
      $display("reset during WAIT abandons fetch");
   endtask

   // Transaction-level reference: one transaction at a time, granted from the
   // requests seen in a free cycle, issued next cycle, answered by handshakes.
   task automatic test_random(input int d, input int cycles);
      logic        busy = 1'b0, in_addr = 1'b0, own_data = 1'b0, dropped = 1'b0, last_data = 1'b0;
      logic        acc_i = 1'b0, acc_d = 1'b0, fl = 1'b0;
      logic        ri, rd, win_data, drop_now, prio;
      logic        e_iao, e_ido, e_dao, e_ddo;
      logic        t_wr;
      logic [1:0]  t_size;
      logic [31:0] t_addr, t_wdata;
      int          n_txn = 0;
      prio = (d == 1);
      t_wr = 1'b0; t_size = 2'b00; t_addr = 32'h0; t_wdata = 32'h0;
      apply_reset(d);
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (!inst_req[d] || acc_i || fl) begin
            inst_req[d]  = 1'($urandom_range(0, 1));
            inst_addr[d] = $urandom & 32'hffff_fffc;
         end
         if (!data_req[d] || acc_d) begin
            data_req[d]   = 1'($urandom_range(0, 1));
            data_wr[d]    = 1'($urandom_range(0, 1));
            data_size[d]  = 2'($urandom_range(0, 3));
            data_addr[d]  = $urandom;
            data_wdata[d] = $urandom;
         end
         flush[d]       = ($urandom_range(0, 7) == 0);
         mem_addr_ok[d] = ($urandom_range(0, 2) == 0);
         mem_data_ok[d] = ($urandom_range(0, 2) == 0);
         mem_rdata[d]   = $urandom;
         mid();
         drop_now = dropped | (busy & ~own_data & flush[d]);
         e_iao = busy & in_addr & mem_addr_ok[d] & ~own_data & ~drop_now;
         e_dao = busy & in_addr & mem_addr_ok[d] & own_data;
         e_ido = busy & ~in_addr & mem_data_ok[d] & ~own_data & ~drop_now;
         e_ddo = busy & ~in_addr & mem_data_ok[d] & own_data;
         n_cmp++;
         if (mem_req[d] !== (busy & in_addr)) begin
            n_bad++;
            $display("FAIL rand_mem_req[%0d] cyc %0d: got %b expected %b", d, c, mem_req[d], busy & in_addr);
         end
         if (busy & in_addr) begin
            n_cmp++;
            if ({mem_addr[d], mem_wr[d], mem_size[d], mem_wdata[d]} !== {t_addr, t_wr, t_size, t_wdata}) begin
               n_bad++;
               $display("FAIL rand_mem_fields[%0d] cyc %0d: got %h/%b/%b/%h expected %h/%b/%b/%h", d, c,
                        mem_addr[d], mem_wr[d], mem_size[d], mem_wdata[d], t_addr, t_wr, t_size, t_wdata);
            end
         end
         n_cmp++;
         if ({inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]} !== {e_iao, e_ido, e_dao, e_ddo}) begin
            n_bad++;
            $display("FAIL rand_oks[%0d] cyc %0d: got %b expected %b", d, c,
                     {inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d]},
                     {e_iao, e_ido, e_dao, e_ddo});
         end
         n_cmp++;
         if ({inst_rdata[d], data_rdata[d]} !== {mem_rdata[d], mem_rdata[d]}) begin
            n_bad++;
            $display("FAIL rand_rdata[%0d] cyc %0d: got %h/%h expected %h", d, c,
                     inst_rdata[d], data_rdata[d], mem_rdata[d]);
         end
         if (e_ido | e_ddo) begin
            $display("rand[%0d] txn %0d %s rdata %h", d, n_txn, own_data ? "data" : "inst", mem_rdata[d]);
         end
         if (busy) begin
            if (in_addr) begin
               dropped = drop_now;
               if (mem_addr_ok[d]) in_addr = 1'b0;
            end else if (mem_data_ok[d]) begin
               busy    = 1'b0;
               dropped = 1'b0;
               n_txn++;
            end else begin
               dropped = drop_now;
            end
         end else begin
            ri = inst_req[d] & ~flush[d];
            rd = data_req[d];
            if (ri | rd) begin
               win_data  = rd & (~ri | prio | ~last_data);
               busy      = 1'b1;
               in_addr   = 1'b1;
               dropped   = 1'b0;
               own_data  = win_data;
               last_data = win_data;
               t_wr      = win_data ? data_wr[d] : 1'b0;
               t_size    = win_data ? data_size[d] : 2'b11;
               t_addr    = win_data ? data_addr[d] : inst_addr[d];
               t_wdata   = win_data ? data_wdata[d] : 32'h0;
            end
         end
         acc_i = inst_addr_ok[d];
         acc_d = data_addr_ok[d];
         fl    = flush[d];
      end
      tick();
      clear_inputs(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         clear_inputs(d);
         reset[d] = 1'b1;
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) reset[d] = 1'b0;
      test_reset(0);
      test_reset(1);
      test_fetch(0);
      test_data_prio(1);
      test_round_robin(0);
      test_flush(0);
      test_reset_in_wait(0);
      test_random(0, 600);
      test_random(1, 600);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
